// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, PC step, reset vector
// and jump offset width.
package cpu_pkg;

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    localparam int          PC_STEP          = 2;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'hC000;
    localparam int          JMP_OFF_W        = 10;

endpackage

// File: rtl/pc_next_calc.sv
// Next fetch pointer: sequential step or relative word jump.
// All arithmetic wraps modulo 2^ADDR_W.
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0]    i_pc,
    input  logic [JMP_OFF_W-1:0] i_pc_offset,
    input  logic                 i_branch_en,
    output logic [ADDR_W-1:0]    o_pc_next
);

    logic [ADDR_W-1:0] w_jmp_bytes;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_step;

    assign w_jmp_bytes = {{(ADDR_W-JMP_OFF_W-1){i_pc_offset[JMP_OFF_W-1]}},
                          i_pc_offset, 1'b0};
    assign w_target    = i_pc + w_jmp_bytes;
    assign w_step      = i_pc + ADDR_W'(PC_STEP);

    // select jump target over the sequential step
    always_comb begin
        o_pc_next = i_branch_en ? w_target : w_step;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory req/ack, valid/ready to control.
// Optional macro FETCH_CNT_EN adds a saturating fetch_count output.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_rd,
    input  logic [15:0]          mem_rdata,
    input  logic                 mem_ack,
    output logic [15:0]          instruction,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    input  logic                 branch_en,
    input  logic [JMP_OFF_W-1:0] pc_offset,
`ifdef FETCH_CNT_EN
    output logic [15:0]          fetch_count,
`endif
    output logic [ADDR_W-1:0]    pc
);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_maddr;
    logic [15:0]       r_instr;
    logic              r_rd;

    logic [1:0]        w_state_nx;
    logic              w_pc_en;
    logic              w_load;
    logic              w_ack;
    logic [ADDR_W-1:0] w_pc_calc;
    logic [ADDR_W-1:0] w_pc_nx;

    // an ack only counts while a read is actually outstanding
    assign w_ack   = mem_ack & r_rd;
    assign w_pc_nx = w_pc_en ? w_pc_calc : r_pc;

    pc_next_calc #(
        .ADDR_W      (ADDR_W)
    ) u_pc_next (
        .i_pc        (r_pc),
        .i_pc_offset (pc_offset),
        .i_branch_en (branch_en),
        .o_pc_next   (w_pc_calc)
    );

    // next-state, PC update enable and instruction capture
    always_comb begin
        w_state_nx = r_state;
        w_pc_en    = 1'b0;
        w_load     = 1'b0;
        unique case (r_state)
            S_REQ: begin
                if (w_ack && !branch_en) begin
                    w_state_nx = S_HOLD;
                    w_pc_en    = 1'b1;
                    w_load     = 1'b1;
                end else if (branch_en) begin
                    w_pc_en    = 1'b1;
                    w_state_nx = (r_rd && !w_ack) ? S_DROP : S_REQ;
                end
            end
            S_HOLD: begin
                if (branch_en) begin
                    w_pc_en    = 1'b1;
                    w_state_nx = S_REQ;
                end else if (inst_ready) begin
                    w_state_nx = S_REQ;
                end
            end
            S_DROP: begin
                w_pc_en = branch_en;
                if (w_ack) begin
                    w_state_nx = S_REQ;
                end
            end
            default: w_state_nx = S_REQ;
        endcase
    end

    // state, PC, read request and address registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_maddr <= RESET_PC;
            r_rd    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
            r_rd    <= (w_state_nx != S_HOLD);
            // address is frozen while a discarded read is in flight
            if (w_state_nx != S_DROP) begin
                r_maddr <= w_pc_nx;
            end
        end
    end

    // instruction latch, written only by a kept read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr <= 16'h0000;
        end else if (w_load) begin
            r_instr <= mem_rdata;
        end
    end

`ifdef FETCH_CNT_EN
    logic [15:0] r_cnt;

    // count accepted instructions that were not flushed by a jump
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 16'h0000;
        end else if ((r_state == S_HOLD) && inst_ready && !branch_en
                     && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign fetch_count = r_cnt;
`endif

    assign mem_addr    = r_maddr;
    assign mem_rd      = r_rd;
    assign instruction = r_instr;
    assign inst_valid  = (r_state == S_HOLD);
    assign pc          = r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level model,
// with a latency-programmable memory responder.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] instruction;
    logic        inst_valid;
    logic        inst_ready;
    logic        branch_en;
    logic [9:0]  pc_offset;
    logic [15:0] pc;
`ifdef FETCH_CNT_EN
    logic [15:0] fetch_count;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // memory responder
    logic        busy;
    logic [15:0] b_addr;
    int          b_wait;
    int          g_lat;

    // reference model
    logic        m_rd, m_valid, m_discard;
    logic [15:0] m_pc, m_inst, m_addr, m_cnt;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .instruction (instruction),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .branch_en   (branch_en),
        .pc_offset   (pc_offset),
`ifdef FETCH_CNT_EN
        .fetch_count (fetch_count),
`endif
        .pc          (pc)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return (a == 16'hC000) ? 16'h4504 : (a ^ 16'hA5A5) + 16'h0101;
    endfunction

    task automatic model_reset();
        m_rd = 0; m_valid = 0; m_discard = 0;
        m_pc = 16'hC000; m_inst = 16'h0000;
        m_addr = 16'hC000; m_cnt = 16'h0000;
        busy = 0; b_wait = 0; b_addr = 16'h0;
    endtask

    task automatic model_step(input logic ack, input logic [15:0] rd,
                              input logic br, input logic [9:0] off,
                              input logic rdy);
        logic [15:0] tgt;
        logic        nr;
        tgt = 16'(int'(m_pc) + 2 * int'($signed(off)));
        nr  = 0;
        if (m_valid) begin
            if (br) begin
                m_pc = tgt; m_valid = 0; nr = 1;
            end else if (rdy) begin
                m_valid = 0; nr = 1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
            end
        end else if (m_rd && !m_discard) begin
            if (ack && br) begin
                m_pc = tgt; nr = 1;
            end else if (ack) begin
                m_inst = rd; m_pc = m_pc + 2; m_valid = 1; m_rd = 0;
            end else if (br) begin
                m_pc = tgt; m_discard = 1;
            end
        end else if (m_rd) begin
            if (br) m_pc = tgt;
            if (ack) nr = 1;
        end else begin
            if (br) m_pc = tgt;
            nr = 1;
        end
        if (nr) begin
            m_rd = 1; m_addr = m_pc; m_discard = 0;
        end
    endtask

    task automatic compare();
        check_eq("mem_rd", mem_rd, m_rd);
        check_eq("inst_valid", inst_valid, m_valid);
        check_eq("pc", pc, m_pc);
        check_eq("instruction", instruction, m_inst);
        if (m_rd) check_eq("mem_addr", mem_addr, m_addr);
`ifdef FETCH_CNT_EN
        check_eq("fetch_count", fetch_count, m_cnt);
`endif
    endtask

    // one clock: check at negedge, drive, model at posedge
    task automatic cycle(input logic br, input logic [9:0] off,
                         input logic rdy);
        compare();
        mem_ack   = 0;
        mem_rdata = 16'($urandom);
        if (busy) check_eq("addr_stable", mem_addr, b_addr);
        if (!busy && mem_rd) begin
            busy   = 1;
            b_addr = mem_addr;
            b_wait = (g_lat < 0) ? int'($urandom_range(0, 3)) : g_lat;
        end
        if (busy) begin
            if (b_wait == 0) begin
                mem_ack   = 1;
                mem_rdata = mdata(b_addr);
                busy      = 0;
            end else begin
                b_wait--;
            end
        end
        branch_en  = br;
        pc_offset  = off;
        inst_ready = rdy;
        @(posedge clk);
        model_step(mem_ack, mem_rdata, br, off, rdy);
        @(negedge clk);
        branch_en = 0;
        mem_ack   = 0;
    endtask

    task automatic wait_valid(input int max);
        int k = 0;
        while (!inst_valid && k < max) begin
            cycle(1'b0, 10'h0, 1'b0);
            k++;
        end
        check_eq("wait_valid", inst_valid, 1);
    endtask

    initial begin
        logic [15:0] diff;
        logic [9:0]  step;
        int          k;
        rst = 1; mem_ack = 0; mem_rdata = 0; inst_ready = 0;
        branch_en = 0; pc_offset = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0;

        check_eq("rst_mem_rd", mem_rd, 0);
        check_eq("rst_valid", inst_valid, 0);
        check_eq("rst_pc", pc, 16'hC000);
        check_eq("rst_addr", mem_addr, 16'hC000);
        check_eq("rst_inst", instruction, 16'h0000);

        g_lat = 0;
        wait_valid(10);
        check_eq("first_inst", instruction, 16'h4504);
        check_eq("first_pc", pc, 16'hC002);
        repeat (5) cycle(1'b0, 10'h0, 1'b0);
        check_eq("hold_valid", inst_valid, 1);
        check_eq("hold_rd", mem_rd, 0);
        cycle(1'b0, 10'h0, 1'b1);
        check_eq("next_rd", mem_rd, 1);
        check_eq("next_addr", mem_addr, 16'hC002);

        wait_valid(10);
        check_eq("pc_c004", pc, 16'hC004);
        cycle(1'b1, 10'h3FE, 1'b0);
        check_eq("br_hold_valid", inst_valid, 0);
        check_eq("br_hold_addr", mem_addr, 16'hC000);

        g_lat = 3;
        wait_valid(20);
        cycle(1'b0, 10'h0, 1'b1);
        check_eq("slow_addr", mem_addr, 16'hC002);
        cycle(1'b0, 10'h0, 1'b0);
        cycle(1'b1, 10'h010, 1'b0);
        k = 0;
        while (!(mem_rd && mem_addr == 16'hC022 && !busy) && k < 10) begin
            cycle(1'b0, 10'h0, 1'b0);
            k++;
        end
        check_eq("drop_target", mem_addr, 16'hC022);
        check_eq("drop_valid", inst_valid, 0);

        g_lat = 0;
        k = 0;
        while (m_pc != 16'hFFFE && k < 100) begin
            diff = 16'hFFFE - m_pc;
            step = (diff / 2 > 16'd511) ? 10'd511 : diff[10:1];
            cycle(1'b1, step, 1'b0);
            k++;
        end
        check_eq("reach_fffe", pc, 16'hFFFE);
        wait_valid(10);
        check_eq("wrap_pc", pc, 16'h0000);
        cycle(1'b1, 10'h3FF, 1'b0);
        check_eq("back_fffe", pc, 16'hFFFE);
        cycle(1'b1, 10'h001, 1'b0);
        check_eq("br_wrap", pc, 16'h0000);

        g_lat = 3;
        cycle(1'b0, 10'h0, 1'b0);
        #2 rst = 1;
        #1;
        check_eq("arst_rd", mem_rd, 0);
        check_eq("arst_valid", inst_valid, 0);
        check_eq("arst_pc", pc, 16'hC000);
`ifdef FETCH_CNT_EN
        check_eq("arst_cnt", fetch_count, 0);
`endif
        @(negedge clk);
        rst = 0;
        model_reset();
        mem_ack = 0;

        g_lat = 1;
        repeat (3) begin
            wait_valid(20);
            cycle(1'b0, 10'h0, 1'b1);
        end
`ifdef FETCH_CNT_EN
        check_eq("cnt_three", fetch_count, 3);
`endif
        check_eq("after_three_pc", pc, 16'hC006);

        g_lat = -1;
        repeat (3000) begin
            cycle($urandom_range(0, 9) == 0, 10'($urandom),
                  1'($urandom_range(0, 1)));
        end
        compare();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
